ram_fifo_fwft: RTL and testbench



---
 rtl/ram_fifo_pkg.sv | 15 +
 rtl/ram_fifo_fwft_if.sv | 35 +++
 rtl/ram_fifo_fwft_ram_1w1r.sv | 39 +++
 rtl/ram_fifo_fwft.sv | 157 +++++++++++++++
 tb/tb_ram_fifo_fwft.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed first-word-fall-through FIFO.
package ram_fifo_pkg;

  // Number of registered entries in front of the RAM that hide its read latency
  localparam int OUT_STAGE_DEPTH = 2;

  // Cycles between issuing a RAM read and the data appearing on the read port
  localparam int RAM_RD_LAT = 1;

  // Width of a counter able to hold every value from 0 up to and including depth
  function automatic int levelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ram_fifo_fwft_if.sv
// Handshake, status and error bundle of the FWFT FIFO.
// The slave side is the FIFO; the master side is whoever drives it.
interface ram_fifo_fwft_if
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int LEVEL_W    = levelWidth(16)
);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LEVEL_W-1:0]    fill_level;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow_err;
  logic                  underflow_err;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, fill_level,
           almost_full, almost_empty, overflow_err, underflow_err
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, fill_level,
           almost_full, almost_empty, overflow_err, underflow_err
  );

endinterface

// File: rtl/ram_fifo_fwft_ram_1w1r.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
// A read of the address being written in the same cycle returns the new data.
module ram_1w1r #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: store the incoming word at the write address
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: register the addressed word, forwarding a same-address write
  always_ff @(posedge clk) begin
    if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_fifo_fwft.sv
// First-word-fall-through FIFO around a registered-read RAM. A two-entry
// output stage (head, next) plus the word currently on the RAM read port
// hide the read latency so one push and one pop per cycle are sustained.
module ram_fifo_fwft
  import ram_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 128,
  parameter int AF_THR     = DEPTH - 2,
  parameter int AE_THR     = 2
) (
  input  logic            clk,
  input  logic            rst,
  ram_fifo_fwft_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = levelWidth(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THR);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THR);
  localparam logic [1:0]    STALL_LIMIT = 2'd2;

  logic [AW-1:0]         wrPtr_q, wrPtr_d;
  logic [AW-1:0]         rdPtr_q, rdPtr_d;
  logic [LW-1:0]         fill_q, fill_d;
  logic [LW-1:0]         ramCount_q, ramCount_d;
  logic                  headValid_q, headValid_d;
  logic                  nextValid_q, nextValid_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] next_q, next_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovErr_q, ovErr_d;
  logic                  unErr_q, unErr_d;
  logic [1:0]            stallCnt_q, stallCnt_d;

  logic [DATA_WIDTH-1:0] ramRdData;
  logic [DATA_WIDTH-1:0] slot0, slot1;
  logic                  slot0V, slot1V, slot2V;
  logic                  inReady, push, pop, issue, ramRe, stallCond;

  ram_1w1r #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wrPtr_q),
    .wdata_i (bus.in_data),
    .re_i    (ramRe),
    .raddr_i (rdPtr_q),
    .rdata_o (ramRdData)
  );

  // Next-state for pointers, occupancy, output stage, flags and sticky errors.
  // The queue order is head, next, then the word on the RAM read port; after a
  // pop the survivors are compacted towards head.
  always_comb begin
    inReady = !rst && !bus.flush && (fill_q < DEPTH_L);

    slot0  = headValid_q ? head_q : ramRdData;
    slot0V = headValid_q | inflight_q;
    slot1  = nextValid_q ? next_q : ramRdData;
    slot1V = headValid_q & (nextValid_q | inflight_q);
    slot2V = headValid_q & nextValid_q & inflight_q;

    push = bus.in_valid & inReady;
    pop  = slot0V & bus.out_ready;

    head_d      = pop ? slot1 : slot0;
    headValid_d = pop ? slot1V : slot0V;
    next_d      = pop ? ramRdData : slot1;
    nextValid_d = pop ? slot2V : slot1V;

    issue      = (ramCount_q != '0) &&
                 ((LW'(headValid_d) + LW'(nextValid_d)) < LW'(OUT_STAGE_DEPTH));
    inflight_d = issue;
    ramCount_d = ramCount_q + LW'(push) - LW'(issue);
    wrPtr_d    = wrPtr_q + AW'(push);
    rdPtr_d    = rdPtr_q + AW'(issue);
    fill_d     = fill_q + LW'(push) - LW'(pop);

    ovErr_d   = ovErr_q | (bus.in_valid & ~inReady & ~bus.flush);
    stallCond = bus.out_ready & ~slot0V & (fill_q != '0);
    unErr_d   = unErr_q | (stallCond & (stallCnt_q == STALL_LIMIT));
    if (!stallCond) begin
      stallCnt_d = 2'd0;
    end else if (stallCnt_q == STALL_LIMIT) begin
      stallCnt_d = stallCnt_q;
    end else begin
      stallCnt_d = stallCnt_q + 2'd1;
    end

    if (bus.flush) begin
      headValid_d = 1'b0;
      nextValid_d = 1'b0;
      inflight_d  = 1'b0;
      ramCount_d  = '0;
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      fill_d      = '0;
      stallCnt_d  = 2'd0;
    end

    af_d = (fill_d >= AF_L);
    ae_d = (fill_d <= AE_L);

    ramRe = issue && !bus.flush && !rst;
  end

  // State register with synchronous reset; flush is handled in next-state
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fill_q      <= '0;
      ramCount_q  <= '0;
      headValid_q <= 1'b0;
      nextValid_q <= 1'b0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      next_q      <= '0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      ovErr_q     <= 1'b0;
      unErr_q     <= 1'b0;
      stallCnt_q  <= 2'd0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fill_q      <= fill_d;
      ramCount_q  <= ramCount_d;
      headValid_q <= headValid_d;
      nextValid_q <= nextValid_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      next_q      <= next_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      ovErr_q     <= ovErr_d;
      unErr_q     <= unErr_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  assign bus.in_ready      = inReady;
  assign bus.out_valid     = slot0V;
  assign bus.out_data      = slot0V ? slot0 : '0;
  assign bus.fill_level    = fill_q;
  assign bus.almost_full   = af_q;
  assign bus.almost_empty  = ae_q;
  assign bus.overflow_err  = ovErr_q;
  assign bus.underflow_err = unErr_q;

endmodule

// File: tb/tb_ram_fifo_fwft.sv
// Self-checking bench for ram_fifo_fwft (DEPTH=16, 128-bit data).
// A queue scoreboard predicts every output each cycle; a vector table and a
// few directed sequences pin down latency, full, flush and reset behaviour.
module tb_ram_fifo_fwft;

  localparam int DEPTH = 16;
  localparam int DW    = 128;
  localparam int LW    = 5;

  typedef struct {
    logic          rst;
    logic          inValid;
    logic [DW-1:0] inData;
    logic          outReady;
    logic          expInReady;
    logic          expOutValid;
    logic          chkData;
    logic [DW-1:0] expData;
    logic [LW-1:0] expFill;
    logic          expAe;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] modelQ [$];
  int            modelPc [$];
  bit            ovModel  = 1'b0;
  bit            unModel  = 1'b0;
  int            stallCnt = 0;

  ram_fifo_fwft_if #(.DATA_WIDTH(DW), .LEVEL_W(LW)) bus ();

  ram_fifo_fwft #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .AF_THR     (DEPTH - 2),
    .AE_THR     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stops advancing
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit modelInReady();
    return !bus.flush && (modelQ.size() < DEPTH);
  endfunction

  function automatic bit modelOutValid();
    if (modelQ.size() == 0) return 1'b0;
    return modelPc[0] <= cyc - 2;
  endfunction

  // Compare every DUT output against the scoreboard for the current cycle
  task automatic checkOutput();
    bit expOv;
    if (rst) begin
      checkVal("in_ready_in_reset", DW'(bus.in_ready), DW'(1'b0));
      return;
    end
    expOv = modelOutValid();
    checkVal("in_ready", DW'(bus.in_ready), DW'(modelInReady()));
    checkVal("out_valid", DW'(bus.out_valid), DW'(expOv));
    checkVal("fill_level", DW'(bus.fill_level), DW'(modelQ.size()));
    checkVal("almost_full", DW'(bus.almost_full), DW'(modelQ.size() >= DEPTH - 2));
    checkVal("almost_empty", DW'(bus.almost_empty), DW'(modelQ.size() <= 2));
    checkVal("overflow_err", DW'(bus.overflow_err), DW'(ovModel));
    checkVal("underflow_err", DW'(bus.underflow_err), DW'(unModel));
    if (expOv) checkVal("out_data", bus.out_data, modelQ[0]);
  endtask

  // Drive one cycle, check at the falling edge, then advance the model
  task automatic applyStimulus(input logic r, input logic fl, input logic iv,
                               input logic [DW-1:0] d, input logic ordy);
    bit expIr, expOv;
    @(posedge clk);
    #1;
    rst           = r;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    checkOutput();
    if (r) begin
      modelQ.delete();
      modelPc.delete();
      ovModel  = 1'b0;
      unModel  = 1'b0;
      stallCnt = 0;
    end else begin
      expIr = modelInReady();
      expOv = modelOutValid();
      if (!fl && iv && !expIr) ovModel = 1'b1;
      if (ordy && !expOv && modelQ.size() > 0) stallCnt++;
      else stallCnt = 0;
      if (stallCnt > 2) unModel = 1'b1;
      if (fl) begin
        modelQ.delete();
        modelPc.delete();
        stallCnt = 0;
      end else begin
        if (expOv && ordy) begin
          void'(modelQ.pop_front());
          void'(modelPc.pop_front());
        end
        if (iv && expIr) begin
          modelQ.push_back(d);
          modelPc.push_back(cyc);
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [DW-1:0] randData();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  vec_t vecs [16];

  initial begin
    bit   savedOv;
    int   bubbles;
    logic [DW-1:0] w;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // rst, iv, data, ordy, expIr, expOv, chkData, expData, expFill, expAe
    vecs[0]  = '{1'b1, 1'b0, 128'h0,  1'b0, 1'b0, 1'b0, 1'b0, 128'h0,  5'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 128'h0,  1'b0, 1'b0, 1'b0, 1'b0, 128'h0,  5'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 128'h0,  1'b0, 1'b1, 1'b0, 1'b1, 128'h0,  5'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 128'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0,  5'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 128'h0,  1'b0, 1'b1, 1'b0, 1'b0, 128'h0,  5'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 128'h0,  1'b0, 1'b1, 1'b1, 1'b1, 128'hA5, 5'd1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 128'h0,  1'b1, 1'b1, 1'b1, 1'b1, 128'hA5, 5'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 128'h0,  1'b0, 1'b1, 1'b0, 1'b0, 128'h0,  5'd0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 128'h11, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0,  5'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 128'h22, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0,  5'd1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 128'h33, 1'b0, 1'b1, 1'b1, 1'b1, 128'h11, 5'd2, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 128'h0,  1'b0, 1'b1, 1'b1, 1'b1, 128'h11, 5'd3, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 128'h0,  1'b1, 1'b1, 1'b1, 1'b1, 128'h11, 5'd3, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 128'h0,  1'b1, 1'b1, 1'b1, 1'b1, 128'h22, 5'd2, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 128'h0,  1'b1, 1'b1, 1'b1, 1'b1, 128'h33, 5'd1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 128'h0,  1'b0, 1'b1, 1'b0, 1'b0, 128'h0,  5'd0, 1'b1};

    // Reset, first-word latency and almost_empty transitions from the table
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, 1'b0, vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
      checkVal("vec_in_ready", DW'(bus.in_ready), DW'(vecs[i].expInReady));
      if (!vecs[i].rst) begin
        checkVal("vec_out_valid", DW'(bus.out_valid), DW'(vecs[i].expOutValid));
        checkVal("vec_fill_level", DW'(bus.fill_level), DW'(vecs[i].expFill));
        checkVal("vec_almost_empty", DW'(bus.almost_empty), DW'(vecs[i].expAe));
        if (vecs[i].chkData) checkVal("vec_out_data", bus.out_data, vecs[i].expData);
      end
    end

    // Fill to capacity without pops, then one push attempt too many
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, randData(), 1'b0);
      if (i == 13) checkVal("af_below_thr", DW'(bus.almost_full), DW'(1'b0));
      if (i == 14) checkVal("af_at_thr", DW'(bus.almost_full), DW'(1'b1));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, randData(), 1'b0);
    checkVal("full_in_ready", DW'(bus.in_ready), DW'(1'b0));
    checkVal("full_level", DW'(bus.fill_level), DW'(DEPTH));
    checkVal("full_af", DW'(bus.almost_full), DW'(1'b1));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkVal("overflow_set", DW'(bus.overflow_err), DW'(1'b1));
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkVal("overflow_sticky", DW'(bus.overflow_err), DW'(1'b1));

    // Full FIFO with push and pop every cycle: wraps the pointers several laps
    bubbles = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, randData(), 1'b1);
      if (bus.out_valid !== 1'b1) bubbles++;
    end
    checkVal("no_bubbles", DW'(bubbles), DW'(0));
    checkVal("steady_level", DW'(bus.fill_level), DW'(DEPTH - 1));

    // Flush with five entries held and a RAM read in flight
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, randData(), 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    savedOv = ovModel;
    applyStimulus(1'b0, 1'b1, 1'b1, randData(), 1'b0);
    checkVal("pre_flush_level", DW'(bus.fill_level), DW'(5));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkVal("flush_out_valid", DW'(bus.out_valid), DW'(1'b0));
    checkVal("flush_level", DW'(bus.fill_level), DW'(0));
    checkVal("flush_keeps_overflow", DW'(bus.overflow_err), DW'(savedOv));
    w = 128'hBEEF;
    applyStimulus(1'b0, 1'b0, 1'b1, w, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkVal("post_flush_valid", DW'(bus.out_valid), DW'(1'b1));
    checkVal("post_flush_first", bus.out_data, w);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Reset while data is being presented, then resume traffic
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, randData(), 1'b0);
    checkVal("mid_out_valid", DW'(bus.out_valid), DW'(1'b1));
    applyStimulus(1'b1, 1'b0, 1'b1, randData(), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkVal("rst_in_ready", DW'(bus.in_ready), DW'(1'b1));
    checkVal("rst_out_valid", DW'(bus.out_valid), DW'(1'b0));
    checkVal("rst_out_data", bus.out_data, '0);
    checkVal("rst_level", DW'(bus.fill_level), DW'(0));
    checkVal("rst_af", DW'(bus.almost_full), DW'(1'b0));
    checkVal("rst_ae", DW'(bus.almost_empty), DW'(1'b1));
    checkVal("rst_overflow", DW'(bus.overflow_err), DW'(1'b0));
    checkVal("rst_underflow", DW'(bus.underflow_err), DW'(1'b0));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), randData(), 1'($urandom_range(0, 1)));
    end

    // Long random traffic at roughly half rate on both sides
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), randData(), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
